// File: rtl/skolem_bvshl_ne_checker.sv
// Sweeps all 256 (s, t) pairs through the 4-bit bvshl != Skolem block and checks (x << s) != t.
// Define CHECKER_STOP_ON_FAIL_EN to end the sweep at the first failing vector.
module skolem_bvshl_ne_checker #(
    parameter int unsigned CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [7:0]       skolem_in,
    input  logic [3:0]       skolem_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic             fail_seen,
    output logic [7:0]       first_fail_vec,
    output logic [3:0]       first_fail_x
);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e           state_q, state_d;
    logic [7:0]       vec_q, vec_d;
    logic             drain_q, drain_d;
    logic             clear;
    logic [7:0]       s1_vec_q;
    logic [3:0]       s1_x_q;
    logic             s1_valid_q, s1_valid_d;
    logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, skip_q, skip_d;
    logic             seen_q, seen_d;
    logic [7:0]       ff_vec_q, ff_vec_d;
    logic [3:0]       ff_x_q, ff_x_d;
    logic             stop_hit, eval_en;
    logic [3:0]       s, t, y;
    logic             ic;

`ifdef CHECKER_STOP_ON_FAIL_EN
    assign stop_hit = seen_q;
`else
    assign stop_hit = 1'b0;
`endif
    // Once stopping, the entry still in stage 1 is dropped uncounted.
    assign eval_en = s1_valid_q & ~stop_hit;

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        drain_d    = drain_q;
        s1_valid_d = 1'b0;
        clear      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d = StSweep;
                    vec_d   = 8'h00;
                    clear   = 1'b1;
                end
            end
            StSweep: begin
                s1_valid_d = 1'b1;
                if (vec_q == 8'hFF) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end else begin
                    vec_d = vec_q + 8'd1;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        if (stop_hit && (state_q == StSweep || state_q == StDrain)) begin
            state_d    = StDone;
            vec_d      = vec_q;
            s1_valid_d = 1'b0;
        end
    end

    assign s  = s1_vec_q[3:0];
    assign t  = s1_vec_q[7:4];
    assign ic = (s < 4'd4) || (t != 4'd0);
    assign y  = (s < 4'd4) ? (s1_x_q << s[1:0]) : 4'd0;

    always_comb begin
        pass_d   = pass_q;
        fail_d   = fail_q;
        skip_d   = skip_q;
        seen_d   = seen_q;
        ff_vec_d = ff_vec_q;
        ff_x_d   = ff_x_q;
        if (clear) begin
            pass_d   = '0;
            fail_d   = '0;
            skip_d   = '0;
            seen_d   = 1'b0;
            ff_vec_d = 8'h00;
            ff_x_d   = 4'h0;
        end else if (eval_en) begin
            if (!ic) begin
                skip_d = skip_q + CNT_W'(1);
            end else if (y != t) begin
                pass_d = pass_q + CNT_W'(1);
            end else begin
                fail_d = fail_q + CNT_W'(1);
                if (!seen_q) begin
                    seen_d   = 1'b1;
                    ff_vec_d = s1_vec_q;
                    ff_x_d   = s1_x_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            vec_q      <= 8'h00;
            drain_q    <= 1'b0;
            s1_vec_q   <= 8'h00;
            s1_x_q     <= 4'h0;
            s1_valid_q <= 1'b0;
            pass_q     <= '0;
            fail_q     <= '0;
            skip_q     <= '0;
            seen_q     <= 1'b0;
            ff_vec_q   <= 8'h00;
            ff_x_q     <= 4'h0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            drain_q    <= drain_d;
            s1_vec_q   <= vec_q;
            s1_x_q     <= skolem_out;
            s1_valid_q <= s1_valid_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            skip_q     <= skip_d;
            seen_q     <= seen_d;
            ff_vec_q   <= ff_vec_d;
            ff_x_q     <= ff_x_d;
        end
    end

    assign skolem_in      = vec_q;
    assign busy           = (state_q == StSweep) || (state_q == StDrain);
    assign done           = (state_q == StDone);
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign skip_cnt       = skip_q;
    assign fail_seen      = seen_q;
    assign first_fail_vec = ff_vec_q;
    assign first_fail_x   = ff_x_q;

endmodule

// File: tb/tb_skolem_bvshl_ne_checker.sv
// Self-checking bench: witness models drive a behavioural sweep model; compares every cycle.
module tb_skolem_bvshl_ne_checker;

    logic       clk = 1'b0;
    logic       rst_n, start;
    logic [7:0] skolem_in;
    logic [3:0] skolem_out;
    logic       busy, done, fail_seen;
    logic [8:0] pass_cnt, fail_cnt, skip_cnt;
    logic [7:0] first_fail_vec;
    logic [3:0] first_fail_x;

    int total = 0;
    int bad   = 0;
    int mode  = 0;  // 0 correct, 1 stuck zero, 2 x=t, 3 random table
    logic [3:0] rand_tab [256];
    bit chk_en = 0;

    typedef struct packed {
        int pass_n;
        int fail_n;
        int skip_n;
        int endk;
        int ffv;
        int ffx;
        bit seen;
    } exp_t;

    always #5 clk = ~clk;

    function automatic logic [3:0] witness(int md, logic [7:0] v, logic [3:0] r);
        case (md)
            0:       return (v[7:4] == 4'd0) ? 4'h1 : 4'h0;
            1:       return 4'h0;
            2:       return v[7:4];
            default: return r;
        endcase
    endfunction

    assign skolem_out = witness(mode, skolem_in, rand_tab[skolem_in]);

    skolem_bvshl_ne_checker #(.CNT_W(9)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .skolem_in(skolem_in),
        .skolem_out(skolem_out), .busy(busy), .done(done), .pass_cnt(pass_cnt),
        .fail_cnt(fail_cnt), .skip_cnt(skip_cnt), .fail_seen(fail_seen),
        .first_fail_vec(first_fail_vec), .first_fail_x(first_fail_x)
    );

    // Whole-sweep outcome straight from the property, plus the cycle at which done rises.
    function automatic exp_t model(int md);
        exp_t r;
        r = '0;
        r.endk = 258;
        for (int v = 0; v < 256; v++) begin
            int s, t, x, y;
            s = v % 16;
            t = v / 16;
            x = int'(witness(md, 8'(v), rand_tab[v]));
            y = (s < 4) ? (x * (1 << s)) % 16 : 0;
            if (!(s < 4 || t != 0)) r.skip_n++;
            else if (y != t) r.pass_n++;
            else begin
                r.fail_n++;
                if (!r.seen) begin
                    r.seen = 1;
                    r.ffv  = v;
                    r.ffx  = x;
`ifdef CHECKER_STOP_ON_FAIL_EN
                    r.endk = v + 3;
                    break;
`endif
                end
            end
        end
        return r;
    endfunction

    function automatic int end_of(int md);
        exp_t r;
        r = model(md);
        return r.endk;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: k = edges since the accepted start.
    bit m_busy, m_done;
    int m_k, m_end;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0;
            m_done <= 0;
            m_k    <= 0;
        end else if (start && !m_busy) begin
            m_busy <= 1;
            m_done <= 0;
            m_k    <= 0;
            m_end  <= end_of(mode);
        end else if (m_busy) begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_end) begin
                m_busy <= 0;
                m_done <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int ev;
            ev = 0;
            if (m_busy || m_done) begin
                ev = m_k;
                if (ev > m_end - 1) ev = m_end - 1;
                if (ev > 255) ev = 255;
            end
            check("skolem_in", int'(skolem_in), ev);
            check("busy", int'(busy), int'(m_busy));
            check("done", int'(done), int'(m_done));
        end
    end

    task automatic kick(input int md);
        mode = md;
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", int'(done), 1);
    endtask

    task automatic check_results(input int md);
        exp_t e;
        e = model(md);
        check("pass_cnt", int'(pass_cnt), e.pass_n);
        check("fail_cnt", int'(fail_cnt), e.fail_n);
        check("skip_cnt", int'(skip_cnt), e.skip_n);
        check("fail_seen", int'(fail_seen), int'(e.seen));
        check("first_fail_vec", int'(first_fail_vec), e.ffv);
        check("first_fail_x", int'(first_fail_x), e.ffx);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pass"}, int'(pass_cnt), 0);
        check({tag, "_fail"}, int'(fail_cnt), 0);
        check({tag, "_skip"}, int'(skip_cnt), 0);
        check({tag, "_seen"}, int'(fail_seen), 0);
        check({tag, "_ffv"}, int'(first_fail_vec), 0);
        check({tag, "_ffx"}, int'(first_fail_x), 0);
        check({tag, "_vec"}, int'(skolem_in), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
    endtask

    initial begin
        int n, p;
        rst_n = 0;
        start = 0;
        for (int i = 0; i < 256; i++) rand_tab[i] = 4'h0;
        repeat (3) @(negedge clk);
        rst_n  = 1;
        chk_en = 1;
        @(negedge clk);
        check_reset_outputs("reset");

        // Correct witness
        kick(0);
        wait_done(n);
        check_results(0);
        check("correct_latency", n, 258);
        check("correct_pass_lit", int'(pass_cnt), 244);
        check("correct_skip_lit", int'(skip_cnt), 12);
        check("correct_fail_lit", int'(fail_cnt), 0);

        // Stuck-zero witness
        kick(1);
        wait_done(n);
        check_results(1);
        check("stuck_ffv_lit", int'(first_fail_vec), 8'h00);
        check("stuck_ffx_lit", int'(first_fail_x), 4'h0);
`ifdef CHECKER_STOP_ON_FAIL_EN
        check("stuck_latency", n, 3);
        check("stuck_fail_lit", int'(fail_cnt), 1);
        check("stuck_pass_lit", int'(pass_cnt), 0);
        check("stuck_skip_lit", int'(skip_cnt), 0);
`else
        check("stuck_latency", n, 258);
        check("stuck_fail_lit", int'(fail_cnt), 4);
        check("stuck_pass_lit", int'(pass_cnt), 240);
        check("stuck_skip_lit", int'(skip_cnt), 12);
`endif

        // x = t: every s=0 vector fails, plus t=0 for s=1..3
        kick(2);
        wait_done(n);
        check_results(2);
        check("xeqt_ffv_lit", int'(first_fail_vec), 8'h00);
        check("xeqt_ffx_lit", int'(first_fail_x), 4'h0);
`ifndef CHECKER_STOP_ON_FAIL_EN
        check("xeqt_fail_lit", int'(fail_cnt), 19);
`endif

        // Reset mid-sweep, then a fresh sweep
        kick(0);
        repeat (99) @(negedge clk);
        #2 rst_n = 0;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_n = 1;
        repeat (5) @(negedge clk);
        check_reset_outputs("idle_after_rst");
        kick(0);
        wait_done(n);
        check_results(0);
        check("post_rst_pass_lit", int'(pass_cnt), 244);

        // start pulse at E50 while busy is ignored
        kick(0);
        repeat (49) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        wait_done(n);
        check("busy_start_latency", n + 50, 258);
        check_results(0);

        // Random witness tables with random start pulses while busy
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) rand_tab[i] = 4'($urandom_range(0, 15));
            kick(3);
            p = $urandom_range(1, 250);
            n = 0;
            while (!done && n < 400) begin
                @(negedge clk);
                n++;
                start = (n == p) && m_busy;
            end
            start = 0;
            check("rand_done", int'(done), 1);
            check("rand_latency", n, end_of(3));
            check_results(3);
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skolem_bvshl_ne_checker.md
# skolem_bvshl_ne_checker

Sequential exhaustive checker for the 4-bit `bvshl` not-equal Skolem function netlist. The block enumerates all 256 (s, t) operand pairs and drives each pair into the combinational Skolem block. It consumes the Skolem block's 4-bit witness `x` and checks the invertibility property `(x << s) != t` wherever the invertibility condition holds. It sits directly around the Skolem block in the verification harness: upstream it feeds that block's inputs, downstream it consumes that block's outputs.

## Interface
- `CNT_W`, default 9: width of the pass, fail and skip counters. Must be ≥ 9 so that 256 is representable.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle request to begin a sweep.
- `skolem_in` out 8: vector driven to the Skolem inputs. Bits [3:0] = s go to i0..i3 (i0 is the LSB). Bits [7:4] = t go to i4..i7.
- `skolem_out` in 4: Skolem witness x, formed as {i11, i10, i9, i8}.
- `busy` out 1: high from the cycle after an accepted `start` until `done` rises.
- `done` out 1: high after a sweep completes; held until the next accepted `start`.
- `pass_cnt`, `fail_cnt`, `skip_cnt` out CNT_W each: per-sweep result counts.
- `fail_seen` out 1: set by the first failure of the sweep.
- `first_fail_vec` out 8: the `skolem_in` value of the first failure.
- `first_fail_x` out 4: the `skolem_out` value of the first failure.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE/DONE → SWEEP when `start`=1. On entry, clear the vector counter, all three counters, `fail_seen`, `first_fail_vec`, `first_fail_x` and `done`.
  - SWEEP: drive the vector counter onto `skolem_in` and increment it each cycle, from 0x00 to 0xFF. After issuing 0xFF, go to DRAIN.
  - DRAIN: wait 2 cycles for the pipeline to empty, then go to DONE.
  - DONE: `done`=1 and `busy`=0.
- `start` while `busy` is ignored.
- Pipeline:
  - Stage 1 registers {`skolem_in`, `skolem_out`, valid}.
  - Stage 2 evaluates the registered pair and updates the counters.
- Evaluation of a stage-1 entry with valid set:
  - Invertibility condition: `ic = (s < 4) | (t != 0)`.
  - `y` = (x << s), truncated to 4 bits; `y` = 0 for s ≥ 4.
  - If !ic: `skip_cnt`++.
  - Else if y != t: `pass_cnt`++.
  - Else: `fail_cnt`++. If `fail_seen`=0, capture `first_fail_vec`/`first_fail_x` and set `fail_seen`.
- Invariant at `done`: `pass_cnt` + `fail_cnt` + `skip_cnt` = 256 (without the stop option).
- `skolem_in` holds its last value when not in SWEEP. In IDLE it is 0x00.

## Timing
- Reset values:
  - `skolem_in`=0x00, `busy`=0, `done`=0.
  - All counters 0, `fail_seen`=0, `first_fail_vec`=0x00, `first_fail_x`=0.
  - State IDLE, pipeline valid bits 0.
- `start` sampled at edge E0:
  - SWEEP from E0.
  - Vector 0x00 is driven during cycle E0..E1.
  - Vector 0xFF is driven during cycle E255..E256.
  - DRAIN covers E256..E258.
  - `done`=1 and `busy`=0 from E258.
- The Skolem path has one full cycle to settle (`skolem_in` register → `skolem_out` → stage-1 register).
- Reset asserted mid-sweep aborts immediately, clears to reset values, and does not restart.
- `start` in the same cycle as `done` rising is accepted on the next edge only (state is DRAIN on that edge).

## Configuration
- `CHECKER_STOP_ON_FAIL_EN` defined:
  - The stage-2 failure that first sets `fail_seen` forces a transition to DONE on the next edge.
  - Any stage-1 entry still in flight is discarded and not counted.
  - The counter sum may then be below 256.
- Undefined: the full 256-vector sweep always runs, regardless of failures.

## Test plan
- Correct witness model, x = (t==0) ? 4'h1 : 4'h0 → `done` at E258; `pass_cnt`=244, `skip_cnt`=12, `fail_cnt`=0, `fail_seen`=0.
- Stuck witness, x=4'h0 → `fail_cnt`=4 (t=0, s=0..3), `pass_cnt`=240, `skip_cnt`=12, `first_fail_vec`=0x00, `first_fail_x`=0x0.
- Witness x=t, all four shift values wrong for s=0 → the s=0 failures are t=0..15 (16 fails). Bench must also check `first_fail_vec`=0x00 and `first_fail_x`=0x0.
- With `CHECKER_STOP_ON_FAIL_EN` and the stuck-zero witness → `done` at E3; `fail_cnt`=1, `pass_cnt`=0, `skip_cnt`=0.
- Assert `rst_n`=0 at E100, then release → all outputs at reset values and state IDLE. A fresh `start` then completes with the correct-model counts.
- `start` pulsed at E50 during a sweep → ignored; the sweep still completes at E258 with unchanged counts.
